spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in sys_clk cycles; legal range 2..255 (>=4 when driving spi_slave on the same sys_clk).
REQ-002 Parameter CS_SETUP, default 2: sys_clk cycles from CS_N fall to first SCK rise phase start; legal range 1..255.
REQ-003 Parameter CS_HOLD, default 2: sys_clk cycles from last SCK fall to CS_N rise; legal range 1..255.
REQ-004 Parameter CS_GAP, default 2: minimum sys_clk cycles CS_N stays high before IDLE; legal range 1..255.
REQ-005 sys_clk  input  1  system clock; all logic on posedge.
REQ-006 rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-007 start  input  1  transfer request, sampled only in IDLE.
REQ-008 txd_data  input  8  byte to send, MSB first, latched on accepted start.
REQ-009 MISO  input  1  serial data from slave.
REQ-010 CS_N  output  1  chip select, active-low, registered.
REQ-011 SCK  output  1  serial clock, mode 0 (idle low), registered.
REQ-012 MOSI  output  1  serial data to slave, registered.
REQ-013 rxd_data  output  8  last received byte, held until next done.
REQ-014 busy  output  1  high from cycle after accepted start until IDLE re-entered.
REQ-015 done  output  1  one-cycle pulse at transfer end.

Function
REQ-016 States SHALL be IDLE, SETUP, LOW, HIGH, HOLD, GAP.
REQ-017 IDLE: start=1 at edge T SHALL latch txd_data; at T+1 CS_N=0, busy=1, MOSI=txd_data[7], state SETUP.
REQ-018 SETUP SHALL last CS_SETUP cycles, SCK=0, then go to LOW.
REQ-019 LOW SHALL last CLK_DIV cycles with SCK=0, then go to HIGH.
REQ-020 The cycle SCK goes 0->1 SHALL shift MISO into the LSB of the receive shift register.
REQ-021 HIGH SHALL last CLK_DIV cycles with SCK=1; bit counter increments on leaving HIGH.
REQ-022 Leaving HIGH with fewer than 8 bits done: SCK=0, MOSI=next bit (MSB-first), go to LOW.
REQ-023 Leaving HIGH after the 8th bit: SCK=0, MOSI=0, go to HOLD.
REQ-024 HOLD SHALL last CS_HOLD cycles with CS_N=0, then CS_N=1, go to GAP.
REQ-025 GAP SHALL last CS_GAP cycles, then IDLE; on IDLE entry rxd_data=received byte, done=1 for one cycle, busy=0 same cycle.
REQ-026 Transfer length, start edge to done-high cycle inclusive: 1+CS_SETUP+16*CLK_DIV+CS_HOLD+CS_GAP cycles.
REQ-027 start while busy=1 SHALL be ignored, not queued.
REQ-028 start=1 in the done cycle SHALL be accepted (back-to-back), CS_N falling the next cycle.
REQ-029 Exactly 8 SCK rising edges per transfer; SCK SHALL never toggle while CS_N=1.
REQ-030 txd_data changes after acceptance SHALL not affect the transfer in flight.
REQ-031 Phase counters SHALL be wide enough for 255; bit counter 4 bits, saturating no wrap within a transfer.

Reset
REQ-032 rst_n low SHALL immediately force CS_N=1, SCK=0, MOSI=0, busy=0, done=0, rxd_data=8'h00, state IDLE, all counters 0.
REQ-033 Reset mid-transfer SHALL abort with no done pulse; first start after release SHALL begin a clean transfer.

Structure
REQ-034 Shared package spi_pkg SHALL hold the state encoding and default CLK_DIV/CS_SETUP/CS_HOLD/CS_GAP constants, shared with spi_slave benches.
REQ-035 Single module; no sub-module: phase counter, bit counter, and TX/RX shift registers inline.

Verification (CLK_DIV=4, CS_SETUP=2, CS_HOLD=2, CS_GAP=2)
REQ-036 Assert rst_n low mid-sim -> same cycle CS_N=1, SCK=0, MOSI=0, busy=0, rxd_data=0x00.
REQ-037 MISO tied to MOSI, start with txd_data=0xA5 -> 8 SCK pulses of 4 high/4 low, MOSI 1,0,1,0,0,1,0,1, done 71 cycles after start edge, rxd_data=0xA5.
REQ-038 MISO driven 0x3C MSB-first, changed only while SCK=0 -> rxd_data=0x3C at done.
REQ-039 start pulsed again at cycle 20 of a transfer -> ignored, exactly one done, busy continuous.
REQ-040 start held high through done, txd 0x0F then 0xF0 -> second CS_N fall in cycle after done, both bytes correct on MOSI.
REQ-041 rst_n low at bit 4 -> no done; release, send 0x81 -> correct 0x81 transfer; with spi_slave attached, its rxd_data=0x81 and rxd_flag pulses once after CS_N rises.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: state encoding, default timing constants and a
// small helper for the terminal count of a phase counter.
package spi_pkg;

  // Default timing, in sys_clk cycles
  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_CS_SETUP = 2;
  localparam int unsigned DEF_CS_HOLD  = 2;
  localparam int unsigned DEF_CS_GAP   = 2;

  localparam int unsigned BITS_PER_XFER = 8;

  // Master state encoding (plain constants so older tools can share them)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  // True on the last cycle of a phase that lasts len cycles (len in 1..255)
  function automatic logic phase_last(input logic [7:0] cnt, input int unsigned len);
    return cnt == 8'(len - 1);
  endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master, mode 0, one byte per transfer, MSB first.
// Frame: CS_N falls, setup delay, 8 SCK periods, hold delay, CS_N rises,
// minimum gap, then done is pulsed together with the received byte.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned CS_SETUP = DEF_CS_SETUP,
  parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
  parameter int unsigned CS_GAP   = DEF_CS_GAP
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] txd_data,
  input  logic       MISO,
  output logic       CS_N,
  output logic       SCK,
  output logic       MOSI,
  output logic [7:0] rxd_data,
  output logic       busy,
  output logic       done
);

  logic [2:0] state_q, state_d;
  logic [7:0] phase_q, phase_d;   // cycles spent in the current state
  logic [3:0] bit_q, bit_d;       // completed SCK periods
  logic [7:0] tx_q, tx_d;         // bit being driven on MOSI sits in [7]
  logic [7:0] rx_q, rx_d;         // receive shift register, fills from LSB
  logic [7:0] rxd_q, rxd_d;
  logic       cs_n_q, cs_n_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] bit_inc;

  // Saturating bit count so a stray extra HIGH phase can never wrap to 0
  assign bit_inc = (bit_q == 4'(BITS_PER_XFER)) ? bit_q : bit_q + 4'd1;

  // Next-state and output logic for the transfer sequencer
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    phase_d = phase_q + 8'd1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = 8'd0;
        if (start) begin
          state_d = ST_SETUP;
          bit_d   = 4'd0;
          tx_d    = txd_data;
          rx_d    = 8'h00;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = txd_data[7];
          busy_d  = 1'b1;
        end
      end

      ST_SETUP: begin
        if (phase_last(phase_q, CS_SETUP)) begin
          state_d = ST_LOW;
          phase_d = 8'd0;
        end
      end

      ST_LOW: begin
        if (phase_last(phase_q, CLK_DIV)) begin
          // Rising SCK edge: MISO has been stable for the whole low phase
          state_d = ST_HIGH;
          phase_d = 8'd0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], MISO};
        end
      end

      ST_HIGH: begin
        if (phase_last(phase_q, CLK_DIV)) begin
          phase_d = 8'd0;
          sck_d   = 1'b0;
          bit_d   = bit_inc;
          if (bit_inc >= 4'(BITS_PER_XFER)) begin
            state_d = ST_HOLD;
            mosi_d  = 1'b0;
          end else begin
            state_d = ST_LOW;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
          end
        end
      end

      ST_HOLD: begin
        if (phase_last(phase_q, CS_HOLD)) begin
          state_d = ST_GAP;
          phase_d = 8'd0;
          cs_n_d  = 1'b1;
        end
      end

      ST_GAP: begin
        if (phase_last(phase_q, CS_GAP)) begin
          state_d = ST_IDLE;
          phase_d = 8'd0;
          bit_d   = 4'd0;
          rxd_d   = rx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = 8'd0;
        bit_d   = 4'd0;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset puts the bus in its idle levels
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= 8'd0;
      bit_q   <= 4'd0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      rxd_q   <= 8'h00;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign CS_N     = cs_n_q;
  assign SCK      = sck_q;
  assign MOSI     = mosi_q;
  assign rxd_data = rxd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
